alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle successor to the datapath ALU. Executes one ALU op per handshake.
//  Add, sub and logic ops complete in 1 cycle; shifts take 1 cycle per bit; MUL is shift-add.
//  Holds the processor flag register (PSR) internally and updates it only on completion.
//  Sits between register-file read/imm-extend stage and writeback; immediates arrive pre-extended on rsrc.
// PARAMETERS
//  WIDTH   16  datapath width in bits (>=4, power of 2)
//  MUL_EN  1   1: MUL (5'b11000) implemented; 0: MUL treated as NOP
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      op/operands valid
//  in_ready   out  1      block can accept (IDLE only)
//  op         in   5      opcode: ADD 00000, ADDU 00010, ADDC 00100, SUB 01000, CMP 01010,
//                         AND 01101, OR 01110, XOR 01111, NOT 10000, LSH 10001, RSH 10011,
//                         ALSH 10101, ARSH 10110, NOP 10111, MUL 11000; other codes = NOP
//  rdest      in   WIDTH  destination operand (A)
//  rsrc       in   WIDTH  source operand / shift amount (B)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  op result, held while out_valid
//  flags      out  5      PSR {C,L,F,Z,N}, registered
//  busy       out  1      high in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, busy=0. Reset mid-op aborts; result lost.
//  Accept when in_valid&&in_ready; operands/op latched that edge. in_ready=0 until DONE handshake.
//  FSM: IDLE -> EXEC (1-cycle ops) | SHIFT | MUL -> DONE -> IDLE.
//   EXEC: compute, go DONE next edge: out_valid on cycle after accept (latency 1).
//   SHIFT: amt = rsrc[$clog2(WIDTH):0], saturated to WIDTH; 1 bit/cycle; amt=0 -> DONE directly.
//     LSH/ALSH zero-fill left; RSH zero-fill right; ARSH sign-fill right. Latency amt+1.
//   MUL (MUL_EN=1): unsigned shift-add over WIDTH cycles; latency WIDTH+1; result = low WIDTH bits.
//   DONE: out_valid=1, result/flags stable until out_ready; same-edge out_ready -> IDLE.
//   No new accept in DONE cycle (in_ready=0): one op in flight max.
//  Arithmetic (WIDTH-bit, two's complement):
//   ADD/ADDU: A+B; ADDC: A+B+flags.C (C sampled at accept). SUB/CMP: A+~B+1.
//   CMP: result=0, flags written; only flags matter.
//  Flag writes (others hold value):
//   ADD/ADDU/ADDC: C=carry out, F=signed overflow, Z=(result==0), L=0, N=0.
//   SUB/CMP: C=no-borrow carry out, F=signed overflow, Z=(A==B), L=A<B unsigned, N=A<B signed.
//   ALSH: F=1 if sign bit changed on any step, else 0; Z=(result==0). Other shifts: Z only.
//   MUL: C=(high WIDTH bits !=0), Z=(low result==0).
//   AND/OR/XOR/NOT/NOP/unknown: flags unchanged; NOT result=~A; NOP result=0.
//  Flags update on the EXEC/SHIFT/MUL -> DONE edge; visible with out_valid.
//  Back-to-back: ADDC accepted after prior ADD sees that ADD's C.
//  MUL_EN=0: MUL -> NOP, latency 1.
// TESTING (WIDTH=16)
//  ADD 0x7FFF+0x0001 -> result 0x8000, flags C=0,F=1,Z=0, out_valid 1 cycle after accept.
//  CMP A=0xFFFF,B=0x0001 -> result 0, L=0,N=1,Z=0,C=1; then AND 0x00F0&0x0FF0 -> 0x00F0, flags unchanged.
//  ARSH A=0x8000,B=3 -> 0xF000 at latency 4; LSH B=0 -> A unchanged, latency 1; B=20 -> 0x0000, latency 17.
//  MUL 0x0100*0x0100 -> result 0x0000, C=1, Z=1, latency 17; 0x0003*0x0005 -> 0x000F, C=0.
//  out_ready held low 5 cycles in DONE -> result/out_valid stable, in_ready=0, next op waits.
//  rst_n low mid-SHIFT -> out_valid=0, flags=0, in_ready=1 immediately (async), new op accepted after release.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: op request / result response handshake bundle for alu_seq
interface alu_seq_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0] op, flags;
  logic [WIDTH-1:0] rdest, rsrc, result;
  modport master (output in_valid, op, rdest, rsrc, out_ready, input in_ready, out_valid, result, flags, busy);
  modport slave (input in_valid, op, rdest, rsrc, out_ready, output in_ready, out_valid, result, flags, busy);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU (1-cycle arith/logic, bit-serial shifts, shift-add MUL) owning the PSR flags
module alu_seq #(
  parameter int WIDTH = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_EXEC = 3'd1, S_SHIFT = 3'd2, S_MUL = 3'd3, S_DONE = 3'd4;
  localparam logic [4:0] OP_ADD = 5'b00000, OP_ADDU = 5'b00010, OP_ADDC = 5'b00100, OP_SUB = 5'b01000,
    OP_CMP = 5'b01010, OP_AND = 5'b01101, OP_OR = 5'b01110, OP_XOR = 5'b01111, OP_NOT = 5'b10000,
    OP_LSH = 5'b10001, OP_RSH = 5'b10011, OP_ALSH = 5'b10101, OP_ARSH = 5'b10110, OP_MUL = 5'b11000;
  logic [2:0] state;
  logic [4:0] opr, psr, ex_flags;
  logic [WIDTH-1:0] a, b, bb, ex_res, res;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] ma, prod;
  logic [CW-1:0] cnt, amt;
  logic alsh_f, is_add, is_sub, is_shift, is_mul, ovf;
  assign bus.in_ready = state == S_IDLE;
  assign bus.out_valid = state == S_DONE;
  assign bus.busy = state != S_IDLE;
  assign bus.result = res;
  assign bus.flags = psr;
  assign is_shift = bus.op inside {OP_LSH, OP_RSH, OP_ALSH, OP_ARSH};
  assign is_mul = MUL_EN && bus.op == OP_MUL;
  assign amt = bus.rsrc[CW-1:0] > CW'(WIDTH) ? CW'(WIDTH) : bus.rsrc[CW-1:0];
  always_comb begin
    is_add = opr inside {OP_ADD, OP_ADDU, OP_ADDC};
    is_sub = opr inside {OP_SUB, OP_CMP};
    bb = is_sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, is_sub || (opr == OP_ADDC && psr[4])};
    ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    case (opr)
      OP_ADD, OP_ADDU, OP_ADDC, OP_SUB: ex_res = sum[WIDTH-1:0];
      OP_AND: ex_res = a & b;
      OP_OR: ex_res = a | b;
      OP_XOR: ex_res = a ^ b;
      OP_NOT: ex_res = ~a;
      default: ex_res = '0;
    endcase
    ex_flags = is_add ? {sum[WIDTH], 1'b0, ovf, sum[WIDTH-1:0] == '0, 1'b0} :
               is_sub ? {sum[WIDTH], a < b, ovf, a == b, $signed(a) < $signed(b)} : psr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      opr <= '0;
      a <= '0;
      b <= '0;
      ma <= '0;
      prod <= '0;
      cnt <= '0;
      alsh_f <= 1'b0;
      res <= '0;
      psr <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          opr <= bus.op;
          a <= bus.rdest;
          b <= bus.rsrc;
          ma <= {{WIDTH{1'b0}}, bus.rdest};
          prod <= '0;
          alsh_f <= 1'b0;
          cnt <= is_mul ? CW'(WIDTH) : amt;
          state <= is_mul ? S_MUL : is_shift ? S_SHIFT : S_EXEC;
        end
        S_EXEC: begin
          res <= ex_res;
          psr <= ex_flags;
          state <= S_DONE;
        end
        S_SHIFT: if (cnt == '0) begin
          res <= a;
          psr <= {psr[4:3], opr == OP_ALSH ? alsh_f : psr[2], a == '0, psr[0]};
          state <= S_DONE;
        end else begin
          a <= opr inside {OP_LSH, OP_ALSH} ? a << 1 : opr == OP_RSH ? a >> 1 : {a[WIDTH-1], a[WIDTH-1:1]};
          alsh_f <= alsh_f | (a[WIDTH-1] ^ a[WIDTH-2]);
          cnt <= cnt - CW'(1);
        end
        S_MUL: if (cnt == '0) begin
          res <= prod[WIDTH-1:0];
          psr <= {|prod[2*WIDTH-1:WIDTH], psr[3:2], prod[WIDTH-1:0] == '0, psr[0]};
          state <= S_DONE;
        end else begin
          prod <= prod + (b[0] ? ma : '0);
          ma <= ma << 1;
          b <= b >> 1;
          cnt <= cnt - CW'(1);
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam logic [4:0] OP_ADD = 5'b00000, OP_ADDU = 5'b00010, OP_ADDC = 5'b00100, OP_SUB = 5'b01000,
    OP_CMP = 5'b01010, OP_AND = 5'b01101, OP_OR = 5'b01110, OP_XOR = 5'b01111, OP_NOT = 5'b10000,
    OP_LSH = 5'b10001, OP_RSH = 5'b10011, OP_ALSH = 5'b10101, OP_ARSH = 5'b10110, OP_NOP = 5'b10111,
    OP_MUL = 5'b11000;
  localparam logic [4:0] OPS [17] = '{OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR,
    OP_NOT, OP_LSH, OP_RSH, OP_ALSH, OP_ARSH, OP_NOP, OP_MUL, 5'b00001, 5'b11111};
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, errors = 0;
  logic [4:0] mf;
  alu_seq_if #(.WIDTH(16)) bus ();
  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic void model(input logic [4:0] o, input int a, input int b, input logic [4:0] fi,
                                output int r, output logic [4:0] fo, output int lat);
    int sa, sb, ss, s, n, cin, ext, mask, w;
    longint p;
    sa = a >= 32768 ? a - 65536 : a;
    sb = b >= 32768 ? b - 65536 : b;
    fo = fi;
    lat = 1;
    r = 0;
    n = b % 32;
    if (n > 16) n = 16;
    case (o)
      OP_ADD, OP_ADDU, OP_ADDC: begin
        cin = (o == OP_ADDC) ? int'(fi[4]) : 0;
        s = a + b + cin;
        ss = sa + sb + cin;
        r = s % 65536;
        fo = {s > 65535, 1'b0, ss > 32767 || ss < -32768, r == 0, 1'b0};
      end
      OP_SUB, OP_CMP: begin
        ss = sa - sb;
        r = (o == OP_CMP) ? 0 : (a - b + 65536) % 65536;
        fo = {a >= b, a < b, ss > 32767 || ss < -32768, a == b, sa < sb};
      end
      OP_AND: r = a & b;
      OP_OR: r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = 65535 - a;
      OP_LSH, OP_ALSH, OP_RSH, OP_ARSH: begin
        r = (o == OP_RSH) ? a >> n : (o == OP_ARSH) ? (sa >>> n) & 65535 : (a << n) & 65535;
        fo[1] = r == 0;
        if (o == OP_ALSH) begin
          ext = a << 1;
          mask = (1 << (n + 1)) - 1;
          w = (ext >> (16 - n)) & mask;
          fo[2] = n > 0 && w != 0 && w != mask;
        end
        lat = n + 1;
      end
      OP_MUL: begin
        p = longint'(a) * longint'(b);
        r = int'(p % 65536);
        fo[4] = (p / 65536) != 0;
        fo[1] = r == 0;
        lat = 17;
      end
      default: r = 0;
    endcase
  endfunction

  task automatic exec_op(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [4:0] f, output int lat);
    int w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    bus.op = o;
    bus.rdest = a;
    bus.rsrc = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!bus.out_valid && lat < 200);
    r = bus.result;
    f = bus.flags;
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic release_op(input int d);
    repeat (d) @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.rdest = '0;
    bus.rsrc = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.result !== 16'h0) begin errors++; $display("FAIL rst_result got %h exp 0000", bus.result); end
    checks++; if (bus.flags !== 5'h0) begin errors++; $display("FAIL rst_flags got %b exp 00000", bus.flags); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    rst_n = 1'b1;
    mf = '0;
  endtask

  task automatic test_add();
    int er, el, l;
    logic [4:0] ef, f;
    logic [15:0] r;
    model(OP_ADD, 'h7FFF, 'h0001, mf, er, ef, el);
    exec_op(OP_ADD, 16'h7FFF, 16'h0001, r, f, l);
    release_op(0);
    mf = ef;
    checks++; if (r !== 16'h8000) begin errors++; $display("FAIL add_ovf_res got %h exp 8000", r); end
    checks++; if (f !== 5'b00100) begin errors++; $display("FAIL add_ovf_flags got %b exp 00100", f); end
    checks++; if (l != 1) begin errors++; $display("FAIL add_latency got %0d exp 1", l); end
    model(OP_ADD, 'hFFFF, 'h0001, mf, er, ef, el);
    exec_op(OP_ADD, 16'hFFFF, 16'h0001, r, f, l);
    release_op(0);
    mf = ef;
    checks++; if (r !== 16'h0000 || f !== 5'b10010) begin errors++; $display("FAIL add_carry got %h/%b exp 0000/10010", r, f); end
    model(OP_ADDC, 'h0001, 'h0001, mf, er, ef, el);
    exec_op(OP_ADDC, 16'h0001, 16'h0001, r, f, l);
    release_op(0);
    mf = ef;
    checks++; if (r !== 16'h0003) begin errors++; $display("FAIL addc_res got %h exp 0003", r); end
    checks++; if (f !== ef) begin errors++; $display("FAIL addc_flags got %b exp %b", f, ef); end
  endtask

  task automatic test_cmp_logic();
    int er, el, l;
    logic [4:0] ef, f;
    logic [15:0] r;
    model(OP_CMP, 'hFFFF, 'h0001, mf, er, ef, el);
    exec_op(OP_CMP, 16'hFFFF, 16'h0001, r, f, l);
    release_op(0);
    mf = ef;
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL cmp_res got %h exp 0000", r); end
    checks++; if (f !== 5'b10001) begin errors++; $display("FAIL cmp_flags got %b exp 10001", f); end
    exec_op(OP_AND, 16'h00F0, 16'h0FF0, r, f, l);
    release_op(0);
    checks++; if (r !== 16'h00F0) begin errors++; $display("FAIL and_res got %h exp 00f0", r); end
    checks++; if (f !== 5'b10001) begin errors++; $display("FAIL and_flags_held got %b exp 10001", f); end
  endtask

  task automatic test_shift();
    logic [4:0] so [4] = '{OP_ARSH, OP_LSH, OP_LSH, OP_ALSH};
    logic [15:0] sa [4] = '{16'h8000, 16'h1234, 16'h1234, 16'h4000};
    logic [15:0] sb [4] = '{16'd3, 16'd0, 16'd20, 16'd1};
    logic [15:0] sr [4] = '{16'hF000, 16'h1234, 16'h0000, 16'h8000};
    int sl [4] = '{4, 1, 17, 2};
    int er, el, l;
    logic [4:0] ef, f;
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      model(so[i], int'(sa[i]), int'(sb[i]), mf, er, ef, el);
      exec_op(so[i], sa[i], sb[i], r, f, l);
      release_op(0);
      mf = ef;
      checks++; if (r !== sr[i]) begin errors++; $display("FAIL shift%0d_res got %h exp %h", i, r, sr[i]); end
      checks++; if (l != sl[i]) begin errors++; $display("FAIL shift%0d_latency got %0d exp %0d", i, l, sl[i]); end
      checks++; if (f !== ef) begin errors++; $display("FAIL shift%0d_flags got %b exp %b", i, f, ef); end
    end
  endtask

  task automatic test_mul();
    int er, el, l;
    logic [4:0] ef, f;
    logic [15:0] r;
    model(OP_MUL, 'h0100, 'h0100, mf, er, ef, el);
    exec_op(OP_MUL, 16'h0100, 16'h0100, r, f, l);
    release_op(0);
    mf = ef;
    checks++; if (r !== 16'h0000 || f[4] !== 1'b1 || f[1] !== 1'b1) begin errors++; $display("FAIL mul_big got %h/%b exp 0000 C=1 Z=1", r, f); end
    checks++; if (l != 17) begin errors++; $display("FAIL mul_latency got %0d exp 17", l); end
    checks++; if (f !== ef) begin errors++; $display("FAIL mul_big_flags got %b exp %b", f, ef); end
    model(OP_MUL, 'h0003, 'h0005, mf, er, ef, el);
    exec_op(OP_MUL, 16'h0003, 16'h0005, r, f, l);
    release_op(0);
    mf = ef;
    checks++; if (r !== 16'h000F || f[4] !== 1'b0) begin errors++; $display("FAIL mul_small got %h/%b exp 000f C=0", r, f); end
  endtask

  task automatic test_stall();
    int er, el, l;
    logic [4:0] ef, f;
    logic [15:0] r;
    model(OP_ADD, 'h1234, 'h1111, mf, er, ef, el);
    exec_op(OP_ADD, 16'h1234, 16'h1111, r, f, l);
    mf = ef;
    bus.op = OP_SUB;
    bus.rdest = 16'hAAAA;
    bus.rsrc = 16'h5555;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 16'h2345 || bus.flags !== ef)
        begin errors++; $display("FAIL stall%0d got ov=%b ir=%b r=%h f=%b exp 1/0/2345/%b", i, bus.out_valid, bus.in_ready, bus.result, bus.flags, ef); end
    end
    release_op(0);
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_accept got busy=%b ov=%b exp 0/0", bus.busy, bus.out_valid); end
  endtask

  task automatic test_random();
    int er, el, l;
    logic [4:0] o, ef, f;
    logic [15:0] a, b, r;
    for (int i = 0; i < 80; i++) begin
      o = OPS[$urandom_range(0, 16)];
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      model(o, int'(a), int'(b), mf, er, ef, el);
      exec_op(o, a, b, r, f, l);
      release_op($urandom_range(0, 2));
      mf = ef;
      checks++; if (r !== er[15:0]) begin errors++; $display("FAIL rnd%0d_res op=%b a=%h b=%h got %h exp %h", i, o, a, b, r, er[15:0]); end
      checks++; if (f !== ef) begin errors++; $display("FAIL rnd%0d_flags op=%b a=%h b=%h got %b exp %b", i, o, a, b, f, ef); end
      checks++; if (l != el) begin errors++; $display("FAIL rnd%0d_latency op=%b b=%h got %0d exp %0d", i, o, b, l, el); end
    end
  endtask

  task automatic test_reset_mid_shift();
    int er, el, l;
    logic [4:0] ef, f;
    logic [15:0] r;
    exec_op(OP_CMP, 16'hFFFF, 16'h0001, r, f, l);
    release_op(0);
    @(negedge clk);
    bus.op = OP_LSH;
    bus.rdest = 16'h0001;
    bus.rsrc = 16'd16;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL midrst_ctrl got ov=%b ir=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, bus.busy); end
    checks++; if (bus.flags !== 5'h0) begin errors++; $display("FAIL midrst_flags got %b exp 00000", bus.flags); end
    mf = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model(OP_ADD, 5, 6, mf, er, ef, el);
    exec_op(OP_ADD, 16'd5, 16'd6, r, f, l);
    release_op(0);
    mf = ef;
    checks++; if (r !== 16'd11 || f !== ef || l != 1) begin errors++; $display("FAIL post_rst_add got %h/%b/%0d exp 000b/%b/1", r, f, l, ef); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp_logic();
    test_shift();
    test_mul();
    test_stall();
    test_random();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
